sid_wr_arb: RTL and testbench

// Arbitrates SID register writes between the host bus (one write per phi2) and an auxiliary

---
 rtl/sid_wr_arb.sv | 165 ++++++++++++++++
 tb/tb_sid_wr_arb.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_wr_arb.sv
// sid_wr_arb
// Merges SID register writes from the host bus and from an auxiliary configuration
// master onto the single sid_control write port.
// - Host writes land in a one-deep pending register. A newer host write replaces it.
// - Aux writes are queued in a FIFO.
// - A grant is issued only when the voice pipeline is in the safe slot (voice_cycle == SLOT).
// - Bus writes win by default. After STARVE_MAX back-to-back bus wins while aux is waiting,
//   aux is forced through once.
//
// Ports
//   clk, res                      clock, synchronous active-low reset
//   voice_cycle                   voice pipeline cycle; grants only when == SLOT
//   bus_we/bus_sid/addr/data      host write, one-clk strobe
//   aux_valid/aux_ready           aux handshake; transfer on valid & ready
//   aux_sid/addr/data             aux write payload
//   wr_en/wr_sid/addr/data        registered write port to sid_control
//   level                         FIFO occupancy 0..DEPTH
//   bus_ovf                       registered pulse: pending host write was overwritten
module sid_wr_arb #(
    parameter int DEPTH      = 8,
    parameter int SLOT       = 0,
    parameter int STARVE_MAX = 4
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic [3:0]                 voice_cycle,
    input  logic                       bus_we,
    input  logic                       bus_sid,
    input  logic [4:0]                 bus_addr,
    input  logic [7:0]                 bus_data,
    input  logic                       aux_valid,
    output logic                       aux_ready,
    input  logic                       aux_sid,
    input  logic [4:0]                 aux_addr,
    input  logic [7:0]                 aux_data,
    output logic                       wr_en,
    output logic                       wr_sid,
    output logic [4:0]                 wr_addr,
    output logic [7:0]                 wr_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       bus_ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    localparam logic [3:0]       SLOT_CYC   = 4'(SLOT);
    localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(DEPTH);
    localparam logic [ST_W-1:0]  STARVE_LIM = ST_W'(STARVE_MAX);

    // Entry layout: {sid, addr[4:0], data[7:0]}
    logic [13:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] lvl_q;
    logic             rdy_q;
    logic [ST_W-1:0]  starve_q;
    logic [ST_W-1:0]  starve_nxt;

    logic             pend_vld_p0;
    logic [13:0]      pend_ent_p0;

    logic             slot_hit;
    logic             fifo_ne;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             gnt_bus;
    logic             gnt_aux;
    logic [13:0]      gnt_ent;

    // rdy_q holds aux_ready low through reset and for the cycle in which res is released.
    assign fifo_full = (lvl_q == FULL_LVL);
    assign aux_ready = rdy_q & ~fifo_full;
    assign level     = lvl_q;

    always_comb begin
        slot_hit   = (voice_cycle == SLOT_CYC);
        fifo_ne    = (lvl_q != '0);
        gnt_bus    = 1'b0;
        gnt_aux    = 1'b0;
        starve_nxt = starve_q;
        if (slot_hit) begin
            if (pend_vld_p0 && fifo_ne) begin
                if (starve_q < STARVE_LIM) begin
                    gnt_bus    = 1'b1;
                    starve_nxt = starve_q + 1'b1;
                end else begin
                    gnt_aux    = 1'b1;
                    starve_nxt = '0;
                end
            end else if (pend_vld_p0) begin
                gnt_bus = 1'b1;
            end else if (fifo_ne) begin
                gnt_aux    = 1'b1;
                starve_nxt = '0;
            end
        end
        // No aux demand means nothing is being starved.
        if (!fifo_ne) begin
            starve_nxt = '0;
        end
        push    = aux_valid & aux_ready;
        pop     = gnt_aux;
        gnt_ent = gnt_bus ? pend_ent_p0 : fifo_mem[rd_ptr];
    end

    // ---- p0: capture (pending register, FIFO) ----
    always_ff @(posedge clk) begin
        if (bus_we) begin
            pend_ent_p0 <= {bus_sid, bus_addr, bus_data};
        end
        if (push) begin
            fifo_mem[wr_ptr] <= {aux_sid, aux_addr, aux_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            rdy_q       <= 1'b0;
            pend_vld_p0 <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            lvl_q       <= '0;
            starve_q    <= '0;
            bus_ovf     <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (bus_we) begin
                pend_vld_p0 <= 1'b1;
            end else if (gnt_bus) begin
                pend_vld_p0 <= 1'b0;
            end
            // A grant in this cycle consumes the old entry, so the new one is not a loss.
            bus_ovf <= bus_we & pend_vld_p0 & ~gnt_bus;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            lvl_q    <= lvl_q + LVL_W'(push) - LVL_W'(pop);
            starve_q <= starve_nxt;
        end
    end

    // ---- p1: registered write port ----
    always_ff @(posedge clk) begin
        if (!res) begin
            wr_en   <= 1'b0;
            wr_sid  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= gnt_bus | gnt_aux;
            if (gnt_bus | gnt_aux) begin
                wr_sid  <= gnt_ent[13];
                wr_addr <= gnt_ent[12:8];
                wr_data <= gnt_ent[7:0];
            end
        end
    end

endmodule

// File: tb/tb_sid_wr_arb.sv
module tb_sid_wr_arb;

    logic       clk;
    logic       res;
    logic [3:0] voice_cycle;
    logic       bus_we;
    logic       bus_sid;
    logic [4:0] bus_addr;
    logic [7:0] bus_data;
    logic       aux_valid;
    logic       aux_ready;
    logic       aux_sid;
    logic [4:0] aux_addr;
    logic [7:0] aux_data;
    logic       wr_en;
    logic       wr_sid;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] level;
    logic       bus_ovf;

    int n_chk;
    int n_fail;

    sid_wr_arb #(.DEPTH(8), .SLOT(0), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .res        (res),
        .voice_cycle(voice_cycle),
        .bus_we     (bus_we),
        .bus_sid    (bus_sid),
        .bus_addr   (bus_addr),
        .bus_data   (bus_data),
        .aux_valid  (aux_valid),
        .aux_ready  (aux_ready),
        .aux_sid    (aux_sid),
        .aux_addr   (aux_addr),
        .aux_data   (aux_data),
        .wr_en      (wr_en),
        .wr_sid     (wr_sid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .level      (level),
        .bus_ovf    (bus_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns later, inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_set(input logic we, input logic sid, input logic [4:0] a, input logic [7:0] d);
        bus_we   = we;
        bus_sid  = sid;
        bus_addr = a;
        bus_data = d;
    endtask

    task automatic aux_set(input logic v, input logic sid, input logic [4:0] a, input logic [7:0] d);
        aux_valid = v;
        aux_sid   = sid;
        aux_addr  = a;
        aux_data  = d;
    endtask

    initial begin
        logic [10:0] pat;
        logic [7:0]  bus_next;
        logic [7:0]  bus_load;
        logic [7:0]  aux_exp_d [2];
        logic [4:0]  aux_exp_a [2];
        int          aux_idx;

        n_chk  = 0;
        n_fail = 0;

        // Reset with aux_valid asserted
        res         = 1'b0;
        voice_cycle = 4'd1;
        bus_set(1'b0, 1'b0, 5'd0, 8'd0);
        aux_set(1'b1, 1'b1, 5'h1F, 8'hEE);
        tick(); tick(); tick();
        chk("rst_ready", aux_ready, 1'b0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_level", level, 4'd0);
        chk("rst_ovf", bus_ovf, 1'b0);
        chk("rst_addr", wr_addr, 5'd0);
        chk("rst_data", wr_data, 8'd0);
        res = 1'b1;
        aux_set(1'b0, 1'b0, 5'd0, 8'd0);
        tick();
        chk("rel_ready", aux_ready, 1'b1);
        chk("rel_level", level, 4'd0);

        // Bus only, SLOT held
        voice_cycle = 4'd0;
        bus_set(1'b1, 1'b0, 5'h18, 8'h0F);
        tick();
        chk("bus_capture_no_wr", wr_en, 1'b0);
        bus_set(1'b0, 1'b0, 5'd0, 8'd0);
        tick();
        chk("bus_wr_en", wr_en, 1'b1);
        chk("bus_wr_sid", wr_sid, 1'b0);
        chk("bus_wr_addr", wr_addr, 5'h18);
        chk("bus_wr_data", wr_data, 8'h0F);
        tick();
        chk("bus_single", wr_en, 1'b0);
        chk("bus_hold_addr", wr_addr, 5'h18);
        chk("bus_hold_data", wr_data, 8'h0F);

        // FIFO fill outside SLOT
        voice_cycle = 4'd1;
        for (int i = 0; i < 8; i++) begin
            aux_set(1'b1, i[0], 5'(i + 1), 8'hA0 + 8'(i));
            tick();
            chk("fill_no_wr", wr_en, 1'b0);
        end
        chk("fill_level", level, 4'd8);
        chk("fill_ready", aux_ready, 1'b0);
        aux_set(1'b1, 1'b1, 5'h1E, 8'hFF);
        tick();
        chk("full_level", level, 4'd8);
        chk("full_ready", aux_ready, 1'b0);
        aux_set(1'b0, 1'b0, 5'd0, 8'd0);
        voice_cycle = 4'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("drain_wr_en", wr_en, 1'b1);
            chk("drain_sid", wr_sid, i[0]);
            chk("drain_addr", wr_addr, 5'(i + 1));
            chk("drain_data", wr_data, 8'hA0 + 8'(i));
        end
        chk("drain_level", level, 4'd0);
        chk("drain_ready", aux_ready, 1'b1);
        tick();
        chk("drain_done", wr_en, 1'b0);

        // Starvation: two aux entries, bus write pending at every SLOT clk
        voice_cycle = 4'd1;
        aux_set(1'b1, 1'b1, 5'h05, 8'hC1);
        tick();
        aux_set(1'b1, 1'b1, 5'h06, 8'hC2);
        tick();
        aux_set(1'b0, 1'b0, 5'd0, 8'd0);
        bus_set(1'b1, 1'b0, 5'h01, 8'h10);
        tick();
        chk("stv_level", level, 4'd2);
        aux_exp_a[0] = 5'h05; aux_exp_d[0] = 8'hC1;
        aux_exp_a[1] = 5'h06; aux_exp_d[1] = 8'hC2;
        pat      = 11'b010_0001_0000;
        bus_next = 8'h10;
        bus_load = 8'h11;
        aux_idx  = 0;
        voice_cycle = 4'd0;
        for (int i = 0; i < 11; i++) begin
            if (!pat[i] && i <= 8) begin
                bus_set(1'b1, 1'b0, 5'h01, bus_load);
            end else begin
                bus_set(1'b0, 1'b0, 5'h01, 8'd0);
            end
            tick();
            chk("stv_wr_en", wr_en, 1'b1);
            chk("stv_ovf", bus_ovf, 1'b0);
            if (pat[i]) begin
                chk("stv_aux_addr", wr_addr, aux_exp_a[aux_idx]);
                chk("stv_aux_data", wr_data, aux_exp_d[aux_idx]);
                aux_idx++;
            end else begin
                chk("stv_bus_addr", wr_addr, 5'h01);
                chk("stv_bus_data", wr_data, bus_next);
                bus_next = bus_load;
                bus_load = bus_load + 8'd1;
            end
        end
        bus_set(1'b0, 1'b0, 5'd0, 8'd0);
        tick();
        chk("stv_done", wr_en, 1'b0);
        chk("stv_level_end", level, 4'd0);

        // Overflow: two bus writes with no SLOT in between
        voice_cycle = 4'd1;
        bus_set(1'b1, 1'b1, 5'h0A, 8'h55);
        tick();
        chk("ovf_first", bus_ovf, 1'b0);
        bus_set(1'b1, 1'b1, 5'h0B, 8'h66);
        tick();
        chk("ovf_pulse", bus_ovf, 1'b1);
        bus_set(1'b0, 1'b0, 5'd0, 8'd0);
        tick();
        chk("ovf_clear", bus_ovf, 1'b0);
        chk("ovf_no_wr", wr_en, 1'b0);
        voice_cycle = 4'd0;
        tick();
        chk("ovf_wr_en", wr_en, 1'b1);
        chk("ovf_wr_sid", wr_sid, 1'b1);
        chk("ovf_wr_addr", wr_addr, 5'h0B);
        chk("ovf_wr_data", wr_data, 8'h66);
        tick();
        chk("ovf_single", wr_en, 1'b0);

        // Simultaneous: new bus write in the cycle the pending one is granted
        bus_set(1'b1, 1'b0, 5'h01, 8'h77);
        tick();
        chk("sim_no_wr", wr_en, 1'b0);
        bus_set(1'b1, 1'b0, 5'h02, 8'h88);
        tick();
        chk("sim_wr1_en", wr_en, 1'b1);
        chk("sim_wr1_data", wr_data, 8'h77);
        chk("sim_ovf1", bus_ovf, 1'b0);
        bus_set(1'b0, 1'b0, 5'd0, 8'd0);
        tick();
        chk("sim_wr2_en", wr_en, 1'b1);
        chk("sim_wr2_addr", wr_addr, 5'h02);
        chk("sim_wr2_data", wr_data, 8'h88);
        chk("sim_ovf2", bus_ovf, 1'b0);
        tick();
        chk("sim_done", wr_en, 1'b0);

        // Reset while writes are queued discards them
        voice_cycle = 4'd1;
        aux_set(1'b1, 1'b0, 5'h03, 8'h33);
        bus_set(1'b1, 1'b0, 5'h04, 8'h44);
        tick();
        chk("mid_level", level, 4'd1);
        aux_set(1'b0, 1'b0, 5'd0, 8'd0);
        bus_set(1'b0, 1'b0, 5'd0, 8'd0);
        res         = 1'b0;
        voice_cycle = 4'd0;
        tick();
        chk("mid_rst_level", level, 4'd0);
        chk("mid_rst_ready", aux_ready, 1'b0);
        chk("mid_rst_wr_en", wr_en, 1'b0);
        res = 1'b1;
        tick();
        chk("mid_rel_wr_en", wr_en, 1'b0);
        chk("mid_rel_ready", aux_ready, 1'b1);
        tick();
        chk("mid_discard", wr_en, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
